instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit_pkg.sv | 19 +
 rtl/instr_fetch_unit_halfword_queue.sv | 66 ++++++
 rtl/instr_fetch_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_unit_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DROP = 2'd3
   } fetch_state_t;

   localparam logic INSTR_LEN_SHORT = 1'b1;
   localparam logic INSTR_LEN_LONG  = 1'b0;

   // A halfword whose two low bits are not both set starts a 16-bit instruction.
   function automatic logic hw_length(input logic [15:0] hw);
      return (hw[1:0] != 2'b11) ? INSTR_LEN_SHORT : INSTR_LEN_LONG;
   endfunction

endpackage

// File: rtl/instr_fetch_unit_halfword_queue.sv
// Circular halfword queue: push 1 or 2, pop 1 or 2, flush, occupancy count.
module halfword_queue #(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = AW + 1
) (
   input  logic          clk,
   input  logic          async_rst_n,
   input  logic          i_flush,
   input  logic          i_push,
   input  logic          i_push_two,
   input  logic [15:0]   i_push_hw0,
   input  logic [15:0]   i_push_hw1,
   input  logic          i_pop,
   input  logic          i_pop_two,
   output logic [15:0]   o_head_hw0,
   output logic [15:0]   o_head_hw1,
   output logic [CW-1:0] o_count
);

   logic [15:0]   r_mem [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic [AW-1:0] w_wr_ptr1;
   logic [AW-1:0] w_rd_ptr1;
   logic [CW-1:0] w_push_n;
   logic [CW-1:0] w_pop_n;

   assign w_wr_ptr1 = r_wr_ptr + AW'(1);
   assign w_rd_ptr1 = r_rd_ptr + AW'(1);
   assign w_push_n  = !i_push ? '0 : (i_push_two ? CW'(2) : CW'(1));
   assign w_pop_n   = !i_pop  ? '0 : (i_pop_two  ? CW'(2) : CW'(1));

   assign o_head_hw0 = r_mem[r_rd_ptr];
   assign o_head_hw1 = r_mem[w_rd_ptr1];
   assign o_count    = r_count;

   // Storage array; contents are only meaningful below the count, so no reset.
   always_ff @(posedge clk) begin
      if (i_push && !i_flush) begin
         r_mem[r_wr_ptr] <= i_push_hw0;
         if (i_push_two) begin
            r_mem[w_wr_ptr1] <= i_push_hw1;
         end
      end
   end

   // Pointer and occupancy update; flush wins over push and pop.
   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + AW'(w_push_n);
         r_rd_ptr <= r_rd_ptr + AW'(w_pop_n);
         r_count  <= r_count + w_push_n - w_pop_n;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: word fetch FSM feeding a halfword queue with
// 16/32-bit length decode at the queue head.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int unsigned INSTR_ADDR_WIDTH = 32,
   parameter int unsigned QUEUE_DEPTH      = 4
) (
   input  logic                        clk,
   input  logic                        async_rst_n,
   input  logic                        clk_en,
   input  logic                        redirect,
   input  logic [INSTR_ADDR_WIDTH-1:0] redirect_addr,
   output logic                        stall,
   output logic                        mem_req_valid,
   output logic [INSTR_ADDR_WIDTH-1:0] mem_req_addr,
   input  logic                        mem_req_ready,
   input  logic                        mem_rsp_valid,
   input  logic [31:0]                 mem_rsp_data,
   output logic                        instr_valid,
   input  logic                        instr_ready,
   output logic [31:0]                 instr_data,
   output logic                        instr_is_short,
   output logic [INSTR_ADDR_WIDTH-1:0] instr_addr
);

   localparam int unsigned W  = INSTR_ADDR_WIDTH;
   localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

   fetch_state_t  r_state;
   logic [W-1:0]  r_fetch_ptr;
   logic [W-1:0]  r_head_addr;
   logic          r_req_valid;

   logic [15:0]   w_hw0;
   logic [15:0]   w_hw1;
   logic [CW-1:0] w_count;
   logic          w_head_short;
   logic          w_complete;
   logic          w_room;
   logic          w_flush;
   logic          w_push;
   logic          w_push_two;
   logic          w_pop;
   logic          w_pop_two;
   logic [15:0]   w_push_hw0;
   logic [W-1:0]  w_redirect_ptr;
   logic [W-1:0]  w_fetch_step;
   logic [W-1:0]  w_head_step;

   assign w_head_short   = (hw_length(w_hw0) == INSTR_LEN_SHORT);
   assign w_complete     = (w_count >= CW'(2)) || ((w_count == CW'(1)) && w_head_short);
   assign w_room         = (w_count <= CW'(QUEUE_DEPTH - 2));
   assign w_redirect_ptr = redirect_addr & ~W'(1);
   assign w_fetch_step   = r_fetch_ptr[1] ? W'(2) : W'(4);
   assign w_head_step    = w_pop_two ? W'(4) : W'(2);

   assign w_flush    = clk_en && redirect;
   assign w_push     = clk_en && !redirect && (r_state == WAIT) && mem_rsp_valid;
   assign w_push_two = !r_fetch_ptr[1];
   assign w_push_hw0 = r_fetch_ptr[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
   assign w_pop      = clk_en && !redirect && w_complete && instr_ready;
   assign w_pop_two  = !w_head_short;

   halfword_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk         (clk),
      .async_rst_n (async_rst_n),
      .i_flush     (w_flush),
      .i_push      (w_push),
      .i_push_two  (w_push_two),
      .i_push_hw0  (w_push_hw0),
      .i_push_hw1  (mem_rsp_data[31:16]),
      .i_pop       (w_pop),
      .i_pop_two   (w_pop_two),
      .o_head_hw0  (w_hw0),
      .o_head_hw1  (w_hw1),
      .o_count     (w_count)
   );

   assign instr_valid    = w_complete;
   assign instr_is_short = w_complete && w_head_short;
   assign instr_data     = !w_complete ? '0 :
                           (w_head_short ? {16'h0000, w_hw0} : {w_hw1, w_hw0});
   assign instr_addr     = r_head_addr;
   assign stall          = !w_complete || !instr_ready;
   assign mem_req_valid  = r_req_valid && clk_en;
   assign mem_req_addr   = {r_fetch_ptr[W-1:2], 2'b00};

   // Fetch FSM with fetch pointer, head address and registered request valid.
   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         r_state     <= IDLE;
         r_fetch_ptr <= '0;
         r_head_addr <= '0;
         r_req_valid <= 1'b0;
      end else if (clk_en) begin
         if (redirect) begin
            r_fetch_ptr <= w_redirect_ptr;
            r_head_addr <= w_redirect_ptr;
            r_req_valid <= 1'b0;
            case (r_state)
               REQ:     r_state <= mem_req_ready ? DROP : IDLE;
               // A response landing with the redirect is the stale one: drop it here.
               WAIT:    r_state <= mem_rsp_valid ? IDLE : DROP;
               DROP:    r_state <= mem_rsp_valid ? IDLE : DROP;
               default: r_state <= IDLE;
            endcase
         end else begin
            if (w_pop) begin
               r_head_addr <= r_head_addr + w_head_step;
            end
            case (r_state)
               IDLE: begin
                  if (w_room) begin
                     r_state     <= REQ;
                     r_req_valid <= 1'b1;
                  end
               end
               REQ: begin
                  if (mem_req_ready) begin
                     r_state     <= WAIT;
                     r_req_valid <= 1'b0;
                  end
               end
               WAIT: begin
                  if (mem_rsp_valid) begin
                     r_state     <= IDLE;
                     r_fetch_ptr <= r_fetch_ptr + w_fetch_step;
                  end
               end
               DROP: begin
                  if (mem_rsp_valid) begin
                     r_state <= IDLE;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule
